// File: rtl/systolic_array_nxn_mm_pkg.sv
// Shared state encoding, default sizes and width helpers for the NxN systolic matrix-multiply engine.
package sa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sa_state_t;

    localparam int SA_N_DEF    = 3;
    localparam int SA_DW_DEF   = 8;
    localparam int SA_KMAX_DEF = 16;

    function automatic int sa_kw(input int kmax);
        return $clog2(kmax) + 1;
    endfunction

    // Widest possible dot product of kmax unsigned dw x dw products.
    function automatic int sa_aw(input int dw, input int kmax);
        return 2 * dw + $clog2(kmax);
    endfunction

endpackage

// File: rtl/systolic_array_nxn_mm_if.sv
// Operand/result handshake bundle between the operand buffers, the engine and the writeback stage.
interface systolic_array_nxn_mm_if
    import sa_pkg::*;
#(
    parameter int N  = SA_N_DEF,
    parameter int DW = SA_DW_DEF,
    parameter int AW = sa_aw(SA_DW_DEF, SA_KMAX_DEF),
    parameter int KW = sa_kw(SA_KMAX_DEF)
) ();

    logic                start;
    logic [KW-1:0]       k_len;
    logic [N*DW-1:0]     a_col;
    logic [N*DW-1:0]     b_row;
    logic                in_valid;
    logic                in_ready;
    logic [N*N*AW-1:0]   result;
    logic                out_valid;
    logic                out_ready;
    logic                busy;

    modport master (
        output start, k_len, a_col, b_row, in_valid, out_ready,
        input  in_ready, result, out_valid, busy
    );

    modport slave (
        input  start, k_len, a_col, b_row, in_valid, out_ready,
        output in_ready, result, out_valid, busy
    );

endinterface

// File: rtl/systolic_array_nxn_mm_pe_mac.sv
// One output-stationary MAC cell: accumulates a*b and forwards a right / b down, all gated by adv.
module pe_mac #(
    parameter int DW = 8,
    parameter int AW = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    output logic [DW-1:0] a_out,
    output logic [DW-1:0] b_out,
    output logic [AW-1:0] acc
);

    logic [2*DW-1:0] prod;

    assign prod = {{DW{1'b0}}, a_in} * {{DW{1'b0}}, b_in};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc   <= '0;
            a_out <= '0;
            b_out <= '0;
        end else if (clr) begin
            acc   <= '0;
            a_out <= '0;
            b_out <= '0;
        end else if (adv) begin
            acc   <= acc + AW'(prod);
            a_out <= a_in;
            b_out <= b_in;
        end
    end

endmodule

// File: rtl/systolic_array_nxn_mm.sv
// Output-stationary NxN systolic matrix multiply: C = A*B over k_len beats, with input skew and stall on bubbles.
// state | meaning
// IDLE  | waiting for start; start clears array and latches k_len
// LOAD  | accepting operand beats, array advances per beat
// DRAIN | zero operands injected for 2N-2 advances to flush the wavefront
// DONE  | result held with out_valid until out_ready
module systolic_array_nxn_mm
    import sa_pkg::*;
#(
    parameter int N    = SA_N_DEF,
    parameter int DW   = SA_DW_DEF,
    parameter int KMAX = SA_KMAX_DEF,
    parameter int AW   = sa_aw(DW, KMAX),
    parameter int KW   = sa_kw(KMAX)
) (
    input logic                    clk,
    input logic                    rst,
    systolic_array_nxn_mm_if.slave bus
);

    localparam int DRAIN_LAST = (N > 1) ? 2 * N - 3 : 0;
    localparam int DCW        = $clog2(2 * N);

    sa_state_t      state, state_nxt;
    logic [KW-1:0]  k_reg, beat_cnt, k_eff;
    logic [DCW-1:0] drain_cnt;
    logic           beat, adv, clr, last_beat;

    logic [DW-1:0]  a_inj [N];
    logic [DW-1:0]  b_inj [N];
    logic [DW-1:0]  a_skw [N];
    logic [DW-1:0]  b_skw [N];
    logic [DW-1:0]  a_src [N][N];
    logic [DW-1:0]  b_src [N][N];
    logic [DW-1:0]  a_fwd [N][N];
    logic [DW-1:0]  b_fwd [N][N];
    logic [AW-1:0]  acc   [N][N];

    assign k_eff     = (bus.k_len > KW'(KMAX)) ? KW'(KMAX) : bus.k_len;
    assign beat      = (state == ST_LOAD) && bus.in_valid;
    assign adv       = beat || (state == ST_DRAIN);
    assign clr       = (state == ST_IDLE) && bus.start;
    assign last_beat = beat && (beat_cnt == k_reg - KW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) state_nxt = (k_eff == '0) ? ST_DONE : ST_LOAD;
            end
            ST_LOAD: begin
                bus.in_ready = 1'b1;
                if (last_beat) state_nxt = (N == 1) ? ST_DONE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_cnt == DCW'(DRAIN_LAST)) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_reg     <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else if (clr) begin
            k_reg     <= k_eff;
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            if (beat)               beat_cnt  <= beat_cnt + KW'(1);
            if (state == ST_DRAIN)  drain_cnt <= drain_cnt + DCW'(1);
        end
    end

    // Row i of A and column i of B are delayed i advances so operands meet diagonally.
    for (genvar i = 0; i < N; i++) begin : g_skew
        assign a_inj[i] = (state == ST_LOAD) ? bus.a_col[i*DW +: DW] : '0;
        assign b_inj[i] = (state == ST_LOAD) ? bus.b_row[i*DW +: DW] : '0;
        if (i == 0) begin : g_direct
            assign a_skw[0] = a_inj[0];
            assign b_skw[0] = b_inj[0];
        end else begin : g_dly
            logic [DW-1:0] a_sr [i];
            logic [DW-1:0] b_sr [i];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst || clr) begin
                    for (int d = 0; d < i; d++) begin
                        a_sr[d] <= '0;
                        b_sr[d] <= '0;
                    end
                end else if (adv) begin
                    a_sr[0] <= a_inj[i];
                    b_sr[0] <= b_inj[i];
                    for (int d = 1; d < i; d++) begin
                        a_sr[d] <= a_sr[d-1];
                        b_sr[d] <= b_sr[d-1];
                    end
                end
            end
            assign a_skw[i] = a_sr[i-1];
            assign b_skw[i] = b_sr[i-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (j == 0) begin : g_a_edge
                assign a_src[i][j] = a_skw[i];
            end else begin : g_a_int
                assign a_src[i][j] = a_fwd[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_src[i][j] = b_skw[j];
            end else begin : g_b_int
                assign b_src[i][j] = b_fwd[i-1][j];
            end
            pe_mac #(.DW(DW), .AW(AW)) u_pe (
                .clk   (clk),
                .rst   (rst),
                .clr   (clr),
                .adv   (adv),
                .a_in  (a_src[i][j]),
                .b_in  (b_src[i][j]),
                .a_out (a_fwd[i][j]),
                .b_out (b_fwd[i][j]),
                .acc   (acc[i][j])
            );
        end
    end

    always_comb begin
        bus.result = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                bus.result[(i*N+j)*AW +: AW] = acc[i][j];
    end

endmodule

// File: tb/tb_systolic_array_nxn_mm.sv
// Self-checking bench for systolic_array_nxn_mm: table-driven runs with a result scoreboard plus corner sequences.
module tb_systolic_array_nxn_mm;
    import sa_pkg::*;

    localparam int N    = 3;
    localparam int DW   = 8;
    localparam int KMAX = 16;
    localparam int AW   = 20;
    localparam int KW   = 5;

    typedef struct {
        int         k_in;
        int         pat;
        int         fill;
        logic [7:0] vmask;
        int         nmask;
        bit         poke;
        int         uni;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    systolic_array_nxn_mm_if #(.N(N), .DW(DW), .AW(AW), .KW(KW)) bus ();
    systolic_array_nxn_mm_if #(.N(1), .DW(DW), .AW(AW), .KW(KW)) bus1 ();

    systolic_array_nxn_mm #(.N(N), .DW(DW), .KMAX(KMAX), .AW(AW), .KW(KW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    systolic_array_nxn_mm #(.N(1), .DW(DW), .KMAX(KMAX), .AW(AW), .KW(KW)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int checks = 0;
    int errors = 0;
    int am [N][KMAX];
    int bm [KMAX][N];
    logic [N*N*AW-1:0] sb_q [$];
    vec_t tbl [6];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint elem(input logic [N*N*AW-1:0] r, input int idx);
        return longint'(r[idx*AW +: AW]);
    endfunction

    task automatic tick(inout int e);
        @(posedge clk);
        e++;
        #1;
    endtask

    task automatic drive_beat(input int kk);
        for (int i = 0; i < N; i++) begin
            bus.a_col[i*DW +: DW] = DW'(am[i][kk]);
            bus.b_row[i*DW +: DW] = DW'(bm[kk][i]);
        end
    endtask

    task automatic push_model(input int k);
        logic [N*N*AW-1:0] r;
        longint s;
        r = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int kk = 0; kk < k; kk++) s += longint'(am[i][kk]) * longint'(bm[kk][j]);
                r[(i*N+j)*AW +: AW] = AW'(s);
            end
        sb_q.push_back(r);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int k, e, first_e, last_e, vi, b, nb;
        logic valid;
        logic [N*N*AW-1:0] exp_r, got;
        k = (v.k_in > KMAX) ? KMAX : v.k_in;
        for (int kk = 0; kk < k; kk++)
            for (int i = 0; i < N; i++) begin
                case (v.pat)
                    0: begin am[i][kk] = (i == kk) ? 1 : 0; bm[kk][i] = kk * N + i + 1; end
                    1: begin am[i][kk] = v.fill; bm[kk][i] = v.fill; end
                    default: begin am[i][kk] = int'($urandom_range(0, 255)); bm[kk][i] = int'($urandom_range(0, 255)); end
                endcase
            end
        push_model(k);

        bus.start = 1'b1;
        bus.k_len = KW'(v.k_in);
        e = 0;
        tick(e);
        bus.start = 1'b0;
        chk($sformatf("v%0d_busy_load", id), bus.busy, 1);
        chk($sformatf("v%0d_in_ready_load", id), bus.in_ready, 1);

        b = 0; vi = 0; nb = 0; first_e = -1;
        while (b < k && vi < 200) begin
            valid = (vi < v.nmask) ? v.vmask[vi] : 1'b1;
            bus.in_valid = valid;
            if (valid) drive_beat(b);
            else begin
                bus.a_col = (N*DW)'($urandom);
                bus.b_row = (N*DW)'($urandom);
            end
            if (v.poke) bus.start = 1'b1;
            tick(e);
            if (valid) begin
                if (first_e < 0) first_e = e;
                b++;
            end else if (first_e >= 0) nb++;
            vi++;
        end
        bus.in_valid = 1'b0;
        bus.start = 1'b0;
        last_e = e;
        chk($sformatf("v%0d_in_ready_after_last", id), bus.in_ready, 0);

        while (!bus.out_valid && e < last_e + 100) tick(e);
        chk($sformatf("v%0d_latency", id), e - first_e + 1, k + nb + 2 * N - 2);
        chk($sformatf("v%0d_out_valid", id), bus.out_valid, 1);
        chk($sformatf("v%0d_busy_done", id), bus.busy, 1);

        got = bus.result;
        if (sb_q.size() == 0) chk($sformatf("v%0d_sb_empty", id), 0, 1);
        else begin
            exp_r = sb_q.pop_front();
            for (int x = 0; x < N * N; x++)
                chk($sformatf("v%0d_C%0d", id, x), elem(got, x), elem(exp_r, x));
        end
        if (v.pat == 0)
            for (int x = 0; x < N * N; x++) chk($sformatf("v%0d_ident_C%0d", id, x), elem(got, x), x + 1);
        if (v.uni >= 0)
            for (int x = 0; x < N * N; x++) chk($sformatf("v%0d_uni_C%0d", id, x), elem(got, x), v.uni);

        if (v.poke) begin
            for (int c = 0; c < 5; c++) begin
                bus.start = 1'b1;
                bus.out_ready = 1'b0;
                tick(e);
                chk($sformatf("v%0d_hold_valid", id), bus.out_valid, 1);
                chk($sformatf("v%0d_hold_result", id), bus.result == got, 1);
            end
            bus.out_ready = 1'b1;
            tick(e);
            chk($sformatf("v%0d_ack_valid", id), bus.out_valid, 0);
            chk($sformatf("v%0d_ack_idle", id), bus.busy, 0);
            bus.start = 1'b0;
            bus.out_ready = 1'b0;
            tick(e);
            chk($sformatf("v%0d_no_restart", id), bus.busy, 0);
        end else begin
            bus.out_ready = 1'b1;
            tick(e);
            bus.out_ready = 1'b0;
            chk($sformatf("v%0d_ack_valid", id), bus.out_valid, 0);
            chk($sformatf("v%0d_ack_idle", id), bus.busy, 0);
        end
    endtask

    initial begin
        int e;
        vec_t v2;
        logic [N*N*AW-1:0] exp_r;
        logic [AW-1:0] exp1;

        bus.start = 0; bus.k_len = '0; bus.a_col = '0; bus.b_row = '0; bus.in_valid = 0; bus.out_ready = 0;
        bus1.start = 0; bus1.k_len = '0; bus1.a_col = '0; bus1.b_row = '0; bus1.in_valid = 0; bus1.out_ready = 0;

        tbl[0] = '{3,  0, 0,   8'h00,        0, 1'b0, -1};
        tbl[1] = '{16, 1, 255, 8'h00,        0, 1'b0, 1040400};
        tbl[2] = '{3,  0, 0,   8'b00101001,  6, 1'b0, -1};
        tbl[3] = '{5,  2, 0,   8'h00,        0, 1'b1, -1};
        tbl[4] = '{20, 2, 0,   8'h00,        0, 1'b0, -1};
        tbl[5] = '{1,  1, 1,   8'h00,        0, 1'b0, 1};

        #12;
        chk("rst_busy", bus.busy, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_result_zero", bus.result == '0, 1);
        chk("rst_n1_result_zero", bus1.result == '0, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int t = 0; t < 6; t++) run_vec(tbl[t], t);

        // k_len=0 goes straight to DONE with cleared accumulators
        e = 0;
        sb_q.push_back('0);
        bus.start = 1'b1;
        bus.k_len = '0;
        tick(e);
        bus.start = 1'b0;
        chk("k0_out_valid", bus.out_valid, 1);
        exp_r = sb_q.pop_front();
        for (int x = 0; x < N * N; x++) chk($sformatf("k0_C%0d", x), elem(bus.result, x), elem(exp_r, x));
        bus.out_ready = 1'b1;
        tick(e);
        bus.out_ready = 1'b0;
        chk("k0_idle", bus.busy, 0);

        // reset during DRAIN discards the partial run
        bus.start = 1'b1;
        bus.k_len = KW'(3);
        tick(e);
        bus.start = 1'b0;
        for (int kk = 0; kk < 3; kk++) begin
            bus.in_valid = 1'b1;
            bus.a_col = (N*DW)'($urandom);
            bus.b_row = (N*DW)'($urandom);
            tick(e);
        end
        bus.in_valid = 1'b0;
        tick(e);
        chk("abort_busy_pre", bus.busy, 1);
        rst = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_in_ready", bus.in_ready, 0);
        chk("abort_result_zero", bus.result == '0, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        v2 = '{4, 1, 2, 8'h00, 0, 1'b0, 16};
        run_vec(v2, 6);

        // single-PE build
        e = 0;
        exp1 = AW'(3 * 4 + 5 * 6);
        bus1.start = 1'b1;
        bus1.k_len = KW'(2);
        tick(e);
        bus1.start = 1'b0;
        chk("n1_in_ready", bus1.in_ready, 1);
        bus1.in_valid = 1'b1;
        bus1.a_col = 8'd3;
        bus1.b_row = 8'd4;
        tick(e);
        bus1.a_col = 8'd5;
        bus1.b_row = 8'd6;
        tick(e);
        bus1.in_valid = 1'b0;
        chk("n1_out_valid", bus1.out_valid, 1);
        chk("n1_result", bus1.result, exp1);
        chk("n1_result_42", bus1.result, 42);
        bus1.out_ready = 1'b1;
        tick(e);
        bus1.out_ready = 1'b0;
        chk("n1_idle", bus1.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
